// File: rtl/bus_io_pkg.sv
// bus_io_pkg: register offsets and bit positions shared by the bus_io_port files
package bus_io_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_IRQ   = 3;
    localparam int CTRL_FLUSH = 0;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte FIFO with a registered head so back-to-back pops need no bubble
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic [7:0] head_q, head_d;
    logic push_ok, pop_ok;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;
    assign head  = head_q;
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        mem_d   = mem_q;
        if (push_ok)
            mem_d[wr_q[AW-1:0]] = din;
        wr_d   = flush ? '0 : (push_ok ? wr_q + ONE : wr_q);
        rd_d   = flush ? '0 : (pop_ok ? rd_q + ONE : rd_q);
        // Next head comes from the post-write memory so a push into an empty FIFO shows up next cycle
        head_d = (wr_d == rd_d) ? 8'h00 : mem_d[rd_d[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= 8'h00;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end
    always_ff @(posedge clk)
        mem_q <= mem_d;
endmodule

// File: rtl/bus_io_port.sv
// bus_io_port: bus-mapped byte output FIFO with status/count regs; BUS_IO_IRQ_EN adds a fill-level irq
module bus_io_port
    import bus_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         DEPTH     = 8
`ifdef BUS_IO_IRQ_EN
    , parameter int       IRQ_THRESH = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    inout  wire  [7:0] data,
    input  logic       cs_input,
    input  logic       we,
    input  logic       oe,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
`ifdef BUS_IO_IRQ_EN
    , output logic     irq
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic hit, wr, rd, push, pop, flush, empty, full, irq_bit;
    logic [CW-1:0] count;
    logic ovf_q, ovf_d, rd_q;
    logic [7:0] last_q, last_d, rd_data_q, rd_data_d, status;
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_ready),
        .flush (flush),
        .din   (data),
        .head  (out_data),
        .empty (empty),
        .full  (full),
        .count (count)
    );
    assign out_valid = !empty;
    assign data = (rd_q && oe && cs_input) ? rd_data_q : 8'hzz;
    always_comb begin
        hit   = cs_input && (addr[7:2] == BASE_ADDR[7:2]);
        wr    = hit && we && !oe;
        rd    = hit && oe && !we;
        push  = wr && (addr[1:0] == REG_DATA);
        flush = wr && (addr[1:0] == REG_CTRL) && data[CTRL_FLUSH];
        pop   = out_valid && out_ready;
        status = 8'h00;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf_q;
        status[ST_IRQ]   = irq_bit;
        // A STATUS read returns the pre-clear ovf and clears it at the same edge
        ovf_d  = flush ? 1'b0 : (push && full && !pop) ? 1'b1 :
                 (rd && addr[1:0] == REG_STATUS) ? 1'b0 : ovf_q;
        last_d = flush ? 8'h00 : (push && (!full || pop)) ? data : last_q;
        rd_data_d = (addr[1:0] == REG_DATA)   ? last_q :
                    (addr[1:0] == REG_STATUS) ? status :
                    (addr[1:0] == REG_COUNT)  ? 8'(count) : 8'h00;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            last_q    <= 8'h00;
            rd_q      <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            ovf_q     <= ovf_d;
            last_q    <= last_d;
            rd_q      <= rd;
            rd_data_q <= rd ? rd_data_d : rd_data_q;
        end
    end
`ifdef BUS_IO_IRQ_EN
    localparam logic [CW-1:0] THRESH = CW'(IRQ_THRESH);
    logic irq_q, irq_d;
    assign irq_d   = count >= THRESH;
    assign irq     = irq_q;
    assign irq_bit = irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end
`else
    assign irq_bit = 1'b0;
`endif
endmodule
